// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
//   state_t : FSM state encoding (IDLE=0, SHIFT=1)
//   clog2   : ceiling log2, floored at 1, used to size the bit counter
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// WIDTH-bit loadable shift register with async active-low reset.
//   clk   : rising-edge clock
//   rst_n : async reset, active low; clears q
//   load  : capture d (has priority over shift)
//   shift : move one place toward the output end, filling with sin
//   sin   : serial fill bit (0 for a transmitter, link bit for a receiver)
//   d     : parallel load data
//   q     : register contents
// DIR=1 shifts toward q[WIDTH-1]; DIR=0 shifts toward q[0].
module shift_reg_piso #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIR   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (DIR != 0) q <= {q[WIDTH-2:0], sin};
      else          q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready word input.
//   Clk      : rising-edge clock
//   Rst      : async reset, active low
//   DataIn   : parallel word, sampled only on the accept edge
//   Load     : word valid; transfer when Load & Ready
//   Ready    : combinational; idle, or retiring the last bit this cycle
//   En       : bit-rate strobe; shifting advances only when high
//   SerOut   : serial data bit (0 when idle)
//   SerValid : SerOut carries a frame bit
//   Busy     : a word is in flight
//   Done     : one-cycle registered pulse after the last bit retires
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Load,
  output logic             Ready,
  input  logic             En,
  output logic             SerOut,
  output logic             SerValid,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned     CW   = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg;
  logic             sr_load, sr_shift;
  logic             done_q, done_nx;
  logic             last;

  assign last = (cnt == LAST);

  shift_reg_piso #(
    .WIDTH (WIDTH),
    .DIR   (MSB_FIRST)
  ) u_shreg (
    .clk   (Clk),
    .rst_n (Rst),
    .load  (sr_load),
    .shift (sr_shift),
    .sin   (1'b0),
    .d     (DataIn),
    .q     (shreg)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    done_nx  = 1'b0;
    Ready    = 1'b0;
    SerValid = 1'b0;
    SerOut   = 1'b0;
    Busy     = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Load) begin
          sr_load  = 1'b1;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        SerValid = 1'b1;
        Busy     = 1'b1;
        SerOut   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
        if (En) begin
          if (!last) begin
            sr_shift = 1'b1;
            cnt_nx   = cnt + CW'(1);
          end else begin
            // Last bit retires this edge: a new word may be taken in the
            // same cycle so back-to-back frames have no idle gap.
            Ready   = 1'b1;
            done_nx = 1'b1;
            if (Load) begin
              sr_load = 1'b1;
              cnt_nx  = '0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         Clk;
  logic         Rst;
  logic [W-1:0] DataIn;
  logic         Load;
  logic         En;
  logic         rdy_m, so_m, sv_m, busy_m, done_m;
  logic         rdy_l, so_l, sv_l, busy_l, done_l;

  int total = 0;
  int bad   = 0;

  // reference model: word in flight and number of bits already retired
  bit           m_busy;
  bit           m_done;
  int unsigned  m_idx;
  logic [W-1:0] m_word;

  // frame scoreboards, one per bit order
  logic [W-1:0] expq_m[$];
  logic [W-1:0] expq_l[$];
  logic [W-1:0] rx_m, rx_l;
  int unsigned  rxn_m, rxn_l;

  int valid_cnt;
  int done_cnt;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .Load(Load), .Ready(rdy_m),
    .En(En), .SerOut(so_m), .SerValid(sv_m), .Busy(busy_m), .Done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .Load(Load), .Ready(rdy_l),
    .En(En), .SerOut(so_l), .SerValid(sv_l), .Busy(busy_l), .Done(done_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect_m(input logic v, input logic b);
    logic [W-1:0] w;
    if (v && En) begin
      rx_m = {rx_m[W-2:0], b};
      rxn_m++;
      if (rxn_m == W) begin
        rxn_m = 0;
        if (expq_m.size() == 0) chk("frame_m_orphan", 32'(rx_m), 32'hFFFF_FFFF);
        else begin
          w = expq_m.pop_front();
          chk("frame_m", 32'(rx_m), 32'(w));
        end
      end
    end
  endtask

  task automatic collect_l(input logic v, input logic b);
    logic [W-1:0] w;
    if (v && En) begin
      rx_l = {b, rx_l[W-1:1]};
      rxn_l++;
      if (rxn_l == W) begin
        rxn_l = 0;
        if (expq_l.size() == 0) chk("frame_l_orphan", 32'(rx_l), 32'hFFFF_FFFF);
        else begin
          w = expq_l.pop_front();
          chk("frame_l", 32'(rx_l), 32'(w));
        end
      end
    end
  endtask

  // Drive one clock cycle of inputs, check outputs mid-cycle, advance model.
  task automatic cycle(input logic ld, input logic [W-1:0] d, input logic e);
    bit   last, rdy, acc, dn;
    logic exp_m, exp_l;
    Load   = ld;
    DataIn = d;
    En     = e;
    @(negedge Clk);
    last  = m_busy && (m_idx == W - 1);
    rdy   = !m_busy || (e && last);
    exp_m = m_busy ? m_word[W-1-m_idx] : 1'b0;
    exp_l = m_busy ? m_word[m_idx]     : 1'b0;
    chk("ready_m",  32'(rdy_m),  32'(rdy));
    chk("ready_l",  32'(rdy_l),  32'(rdy));
    chk("serval_m", 32'(sv_m),   32'(m_busy));
    chk("serval_l", 32'(sv_l),   32'(m_busy));
    chk("busy_m",   32'(busy_m), 32'(m_busy));
    chk("busy_l",   32'(busy_l), 32'(m_busy));
    chk("done_m",   32'(done_m), 32'(m_done));
    chk("done_l",   32'(done_l), 32'(m_done));
    chk("serout_m", 32'(so_m),   32'(exp_m));
    chk("serout_l", 32'(so_l),   32'(exp_l));
    collect_m(sv_m, so_m);
    collect_l(sv_l, so_l);
    if (sv_m)   valid_cnt++;
    if (done_m) done_cnt++;
    acc = ld && rdy;
    dn  = m_busy && e && last;
    if (m_busy && e) begin
      if (last) m_busy = 1'b0;
      else      m_idx  = m_idx + 1;
    end
    if (acc) begin
      m_busy = 1'b1;
      m_word = d;
      m_idx  = 0;
      expq_m.push_back(d);
      expq_l.push_back(d);
    end
    m_done = dn;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Load = 1'b0;
    En   = 1'b0;
    Rst  = 1'b0;
    #2;
    chk("rst_serval_m", 32'(sv_m),   32'd0);
    chk("rst_serval_l", 32'(sv_l),   32'd0);
    chk("rst_busy_m",   32'(busy_m), 32'd0);
    chk("rst_done_m",   32'(done_m), 32'd0);
    chk("rst_serout_m", 32'(so_m),   32'd0);
    chk("rst_serout_l", 32'(so_l),   32'd0);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
    expq_m.delete();
    expq_l.delete();
    rxn_m = 0;
    rxn_l = 0;
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst    = 1'b0;
    Load   = 1'b0;
    En     = 1'b0;
    DataIn = '0;
    rx_m   = '0;
    rx_l   = '0;
    #1;

    // reset and idle
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // single word A5 (MSB instance) and the same word LSB first
    valid_cnt = 0; done_cnt = 0;
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, W'($urandom), 1'b1);
    chk("a5_valid_cycles", 32'(valid_cnt), 32'd8);
    chk("a5_done_count",   32'(done_cnt),  32'd1);

    // word 01, checks the LSB-first instance sends 1 then seven 0s
    cycle(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);

    // paced shifting: En every 3rd cycle, mid-frame loads ignored
    valid_cnt = 0; done_cnt = 0;
    cycle(1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 28; k++) begin
      cycle((k < 20) && (k % 4 == 1), 8'h3C, (k % 3) == 2);
    end
    chk("paced_valid_cycles", 32'(valid_cnt), 32'd24);
    chk("paced_done_count",   32'(done_cnt),  32'd1);

    // back-to-back FF then 00 with Load held high
    valid_cnt = 0; done_cnt = 0;
    cycle(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 8'hFF, 1'b1);
    chk("b2b_valid_cycles", 32'(valid_cnt), 32'd16);
    chk("b2b_done_count",   32'(done_cnt),  32'd2);

    // reset mid-frame after 3 bits of 96, then 5A
    cycle(1'b1, 8'h96, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1);
    do_reset();
    valid_cnt = 0; done_cnt = 0;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("rst_mid_valid_cycles", 32'(valid_cnt), 32'd8);
    chk("rst_mid_done_count",   32'(done_cnt),  32'd1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      cycle(($urandom % 4) == 0, W'($urandom), ($urandom % 3) != 0);
    end
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("drain_q_m", 32'(expq_m.size()), 32'd0);
    chk("drain_q_l", 32'(expq_l.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
